// File: rtl/calc_ctrl.sv
// calc_ctrl: sequencer for a small register-file/ALU datapath.
// Steps LOAD1 (R1<-in1), LOAD2 (R2<-in2), EXEC (R3<-R1 op R2), OUT (R3 to
// the output mux for OUT_HOLD cycles) and DONE. It then returns to IDLE.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   go              start request, sampled only in IDLE
//   op_sel[1:0]     11 add, 10 subtract, 01 AND, 00 XOR (latched on accept)
//   s1, wa, we      MUX1 select, write address, write enable
//   raa, rea        read port A address/enable
//   rab, reb        read port B address/enable
//   c, s2           ALU operation code, output MUX2 select
//   busy, done, cs  status: not-IDLE, one-cycle completion pulse, state code
module calc_ctrl #(
  parameter int unsigned OUT_HOLD = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [1:0] op_sel,
  output logic [1:0] s1,
  output logic [1:0] wa,
  output logic       we,
  output logic [1:0] raa,
  output logic       rea,
  output logic [1:0] rab,
  output logic       reb,
  output logic [1:0] c,
  output logic       s2,
  output logic       busy,
  output logic       done,
  output logic [2:0] cs
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD1 = 3'd1,
    LOAD2 = 3'd2,
    EXEC  = 3'd3,
    OUT   = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t     state;
  state_t     state_n;
  logic [1:0] op_q;
  logic [3:0] cnt;

  assign cs = state;

  // Control word layout: s1_wa_we_raa_rea_rab_reb_c_s2
  function automatic logic [13:0] ctrl_word(input state_t st, input logic [1:0] op);
    case (st)
      LOAD1:   return 14'b11_01_1_00_0_00_0_00_0;
      LOAD2:   return 14'b10_10_1_00_0_00_0_00_0;
      EXEC:    return {11'b00_11_1_01_1_10_1, op, 1'b0};
      OUT:     return 14'b01_00_0_11_1_11_1_01_1;
      default: return 14'b01_00_0_00_0_00_0_00_0;
    endcase
  endfunction

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = go ? LOAD1 : IDLE;
      LOAD1:   state_n = LOAD2;
      LOAD2:   state_n = EXEC;
      EXEC:    state_n = OUT;
      OUT:     state_n = (cnt == '0) ? DONE : OUT;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register and stay registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_q  <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      {s1, wa, we, raa, rea, rab, reb, c, s2} <= ctrl_word(IDLE, 2'b00);
    end else begin
      state <= state_n;
      if (state == IDLE && go)
        op_q <= op_sel;
      if (state != OUT && state_n == OUT)
        cnt <= 4'(OUT_HOLD - 1);
      else if (state == OUT && cnt != '0)
        cnt <= cnt - 4'd1;
      busy <= (state_n != IDLE);
      done <= (state_n == DONE);
      // op_q is already settled before EXEC is ever entered.
      {s1, wa, we, raa, rea, rab, reb, c, s2} <= ctrl_word(state_n, op_q);
    end
  end

endmodule

// File: tb/tb_calc_ctrl.sv
// Testbench for calc_ctrl: directed vector table, OUT_HOLD=3 back-to-back
// run, datapath sweep over all ops/operands, and randomized run against a
// phase-count reference model.
module tb_calc_ctrl;

  localparam logic [13:0] W_IDLE  = 14'b01_00_0_00_0_00_0_00_0;
  localparam logic [13:0] W_L1    = 14'b11_01_1_00_0_00_0_00_0;
  localparam logic [13:0] W_L2    = 14'b10_10_1_00_0_00_0_00_0;
  localparam logic [10:0] EXEC_HI = 11'b00_11_1_01_1_10_1;
  localparam logic [13:0] W_OUT   = 14'b01_00_0_11_1_11_1_01_1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT a: default OUT_HOLD=1
  logic       rst_a, go_a;
  logic [1:0] op_a;
  logic [1:0] s1_a, wa_a, raa_a, rab_a, c_a;
  logic       we_a, rea_a, reb_a, s2_a, busy_a, done_a;
  logic [2:0] cs_a;
  logic [13:0] word_a;

  // DUT b: OUT_HOLD=3
  logic       rst_b, go_b;
  logic [1:0] op_b;
  logic [1:0] s1_b, wa_b, raa_b, rab_b, c_b;
  logic       we_b, rea_b, reb_b, s2_b, busy_b, done_b;
  logic [2:0] cs_b;
  logic [13:0] word_b;

  assign word_a = {s1_a, wa_a, we_a, raa_a, rea_a, rab_a, reb_a, c_a, s2_a};
  assign word_b = {s1_b, wa_b, we_b, raa_b, rea_b, rab_b, reb_b, c_b, s2_b};

  calc_ctrl u_dut_a (
    .clk(clk), .rst(rst_a), .go(go_a), .op_sel(op_a),
    .s1(s1_a), .wa(wa_a), .we(we_a), .raa(raa_a), .rea(rea_a),
    .rab(rab_a), .reb(reb_a), .c(c_a), .s2(s2_a),
    .busy(busy_a), .done(done_a), .cs(cs_a)
  );

  calc_ctrl #(.OUT_HOLD(3)) u_dut_b (
    .clk(clk), .rst(rst_b), .go(go_b), .op_sel(op_b),
    .s1(s1_b), .wa(wa_b), .we(we_b), .raa(raa_b), .rea(rea_b),
    .rab(rab_b), .reb(reb_b), .c(c_b), .s2(s2_b),
    .busy(busy_b), .done(done_b), .cs(cs_b)
  );

  // Datapath around DUT a: 4 x 3-bit register file, MUX1, ALU, MUX2.
  logic [2:0] rf [4];
  logic [2:0] in1, in2;
  logic [2:0] rd_a, rd_b, alu, mux1, dp_out;

  always_comb begin
    rd_a = rea_a ? rf[raa_a] : 3'd0;
    rd_b = reb_a ? rf[rab_a] : 3'd0;
    case (c_a)
      2'b11:   alu = rd_a + rd_b;
      2'b10:   alu = rd_a - rd_b;
      2'b01:   alu = rd_a & rd_b;
      default: alu = rd_a ^ rd_b;
    endcase
    case (s1_a)
      2'b11:   mux1 = in1;
      2'b10:   mux1 = in2;
      2'b00:   mux1 = alu;
      default: mux1 = 3'd0;
    endcase
    dp_out = s2_a ? alu : 3'd0;
  end

  always @(posedge clk)
    if (we_a) rf[wa_a] <= mux1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: k counts cycles since acceptance (0 = idle). The sequence is
  // 1 LOAD1, 2 LOAD2, 3 EXEC, 4..3+h OUT, 4+h DONE.
  function automatic logic [18:0] expect_obs(input int k, input int h, input logic [1:0] lop);
    logic [2:0]  ecs;
    logic [13:0] w;
    if (k == 0)           ecs = 3'd0;
    else if (k <= 3)      ecs = 3'(k);
    else if (k <= 3 + h)  ecs = 3'd4;
    else                  ecs = 3'd5;
    case (ecs)
      3'd1:    w = W_L1;
      3'd2:    w = W_L2;
      3'd3:    w = {EXEC_HI, lop, 1'b0};
      3'd4:    w = W_OUT;
      default: w = W_IDLE;
    endcase
    return {ecs, w, (k != 0), (k == 4 + h)};
  endfunction

  function automatic int model_next(input int k, input int h, input logic r, input logic g);
    if (r)           return 0;
    if (k == 0)      return g ? 1 : 0;
    if (k == 4 + h)  return 0;
    return k + 1;
  endfunction

  typedef struct {
    logic        rst;
    logic        go;
    logic [1:0]  op;
    logic [2:0]  cs;
    logic [13:0] word;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int ka, kb, n, ndone, last_done, run;
    logic [1:0] la, lb;
    logic ra, ga, rb, gb;
    logic [1:0] oa, ob;
    int ref_v;

    for (int i = 0; i < 4; i++) rf[i] = 3'd0;
    in1 = 3'd0; in2 = 3'd0;
    rst_a = 1'b1; go_a = 1'b0; op_a = 2'b00;
    rst_b = 1'b1; go_b = 1'b0; op_b = 2'b00;

    // rst, go, op -> cs, word, busy, done
    tbl[0]  = '{1'b1, 1'b0, 2'b00, 3'd0, W_IDLE, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 2'b11, 3'd1, W_L1,   1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 2'b00, 3'd2, W_L2,   1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 2'b00, 3'd3, {EXEC_HI, 2'b11, 1'b0}, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 2'b00, 3'd4, W_OUT,  1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 2'b01, 3'd5, W_IDLE, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 2'b00, 3'd0, W_IDLE, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 2'b00, 3'd0, W_IDLE, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 2'b10, 3'd1, W_L1,   1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 2'b00, 3'd2, W_L2,   1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 2'b00, 3'd3, {EXEC_HI, 2'b10, 1'b0}, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 2'b00, 3'd0, W_IDLE, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 2'b00, 3'd0, W_IDLE, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 2'b00, 3'd0, W_IDLE, 1'b0, 1'b0};

    tick();
    for (int i = 0; i < 14; i++) begin
      rst_a = tbl[i].rst; go_a = tbl[i].go; op_a = tbl[i].op;
      tick();
      check($sformatf("vec%0d", i), {13'd0, cs_a, word_a, busy_a, done_a},
            {13'd0, tbl[i].cs, tbl[i].word, tbl[i].busy, tbl[i].done});
    end

    // OUT_HOLD=3 with go held high: done at 7, 15, 23, 31; s2 runs of 3.
    rst_b = 1'b1; tick();
    rst_b = 1'b0; go_b = 1'b1;
    ndone = 0; last_done = 0; run = 0;
    for (int t = 1; t <= 34; t++) begin
      op_b = 2'($urandom_range(0, 3));
      tick();
      if (done_b) begin
        if (ndone == 0) check("hold3_first_done", t, 7);
        else            check("hold3_done_period", t - last_done, 8);
        ndone++;
        last_done = t;
      end
      if (s2_b) run++;
      else if (run != 0) begin
        check("hold3_s2_len", run, 3);
        run = 0;
      end
    end
    check("hold3_done_count", ndone, 4);
    go_b = 1'b0;

    // Datapath sweep on DUT a; op_sel is disturbed right after acceptance.
    rst_a = 1'b1; tick(); rst_a = 1'b0;
    for (int op = 0; op < 4; op++)
      for (int a = 0; a < 8; a++)
        for (int b = 0; b < 8; b++) begin
          in1 = 3'(a); in2 = 3'(b); op_a = 2'(op); go_a = 1'b1;
          tick();
          go_a = 1'b0; op_a = ~op_a;
          n = 0;
          while (cs_a != 3'd4 && n < 10) begin tick(); n++; end
          check("dp_cs", cs_a, 3'd4);
          case (op)
            3:       ref_v = (a + b) % 8;
            2:       ref_v = (a - b + 8) % 8;
            1:       ref_v = a & b;
            default: ref_v = a ^ b;
          endcase
          check($sformatf("dp_op%0d_%0d_%0d", op, a, b), dp_out, ref_v);
          n = 0;
          while (cs_a != 3'd0 && n < 10) begin tick(); n++; end
        end

    // Randomized run on both DUTs against the phase-count model.
    rst_a = 1'b1; rst_b = 1'b1; go_a = 1'b0; go_b = 1'b0;
    tick();
    ka = 0; kb = 0; la = 2'b00; lb = 2'b00;
    for (int t = 0; t < 600; t++) begin
      ra = ($urandom_range(0, 39) == 0);
      rb = ($urandom_range(0, 39) == 0);
      ga = $urandom_range(0, 1) == 1;
      gb = $urandom_range(0, 1) == 1;
      oa = 2'($urandom_range(0, 3));
      ob = 2'($urandom_range(0, 3));
      rst_a = ra; go_a = ga; op_a = oa;
      rst_b = rb; go_b = gb; op_b = ob;
      tick();
      if (ra) la = 2'b00; else if (ka == 0 && ga) la = oa;
      if (rb) lb = 2'b00; else if (kb == 0 && gb) lb = ob;
      ka = model_next(ka, 1, ra, ga);
      kb = model_next(kb, 3, rb, gb);
      check("rand_a", {13'd0, cs_a, word_a, busy_a, done_a}, {13'd0, expect_obs(ka, 1, la)});
      check("rand_b", {13'd0, cs_b, word_b, busy_b, done_b}, {13'd0, expect_obs(kb, 3, lb)});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
